fp_compare_pipe: RTL and testbench
==================================

FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 SHALL have parameter FPWID, default 64, operand width; legal values 16, 32, 64, 128.
REQ-002 SHALL have parameter TAGW, default 4, width of the caller tag carried alongside each compare.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, operands a/b/in_tag present.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have ports a, b, input, FPWID each, IEEE 754 operands.
REQ-008 SHALL have port in_tag, input, TAGW, opaque caller tag.
REQ-009 SHALL have port out_valid, input/output pair: out_valid output 1, out_ready input 1.
REQ-010 SHALL have port o, output, 16, compare result vector; out_tag, output, TAGW.
REQ-011 SHALL have ports nan, snan, inf, output, 1 each, per-result exception flags.
REQ-012 SHALL have port snan_sticky, output, 1, and flag_clr, input, 1, sticky signalling-NaN flag and its clear.

Function
REQ-013 SHALL be a 2-stage pipeline: stage 1 registers decomposed operands; stage 2 registers o, flags, out_tag; latency exactly 2 cycles with no stall.
REQ-014 SHALL accept a transfer when in_valid & in_ready; SHALL deliver when out_valid & out_ready.
REQ-015 SHALL advance each stage when it is empty or the downstream stage advances; in_ready = ~v1 | adv1 (combinational from out_ready).
REQ-016 SHALL hold o, flags, out_tag stable while out_valid & ~out_ready; sustain 1 result/cycle when out_ready stays high.
REQ-017 SHALL set o bits: 0 eq, 1 lt, 2 le, 3 magnitude lt, 4 unordered, 8 ne, 9 ge, 10 gt, 11 magnitude ge, 12 ordered; 7:5 and 15:14 zero.
REQ-018 SHALL treat +0 and -0 as equal; eq, lt, le, ge, gt SHALL be 0 when either operand is NaN; ne SHALL be 1 when unordered.
REQ-019 SHALL compute magnitude lt/ge on {exponent,fraction} ignoring sign, infinity above all finite values.
REQ-020 SHALL compute signed lt: differing signs -> lt = sa unless both zero; both negative -> magnitude gt; both positive -> magnitude lt.
REQ-021 SHALL set nan = either NaN or both infinite; snan = either operand NaN with fraction MSB clear; inf = both infinite.
REQ-022 SHALL set snan_sticky on any delivered result with snan=1; flag_clr clears it; simultaneous clear and set -> set wins.

Reset
REQ-023 SHALL on rst clear both stage valids, out_valid=0, o=0, nan=snan=inf=0, out_tag=0, snan_sticky=0; in_ready=1 in the cycle after rst deasserts.
REQ-024 SHALL discard any in-flight compare when rst asserts mid-operation; no result from before reset is ever delivered.

Configuration
REQ-025 SHALL support macro FP_CMP_TOTALORDER_EN: when defined, o[13] = IEEE 754 totalOrder(a,b) strict-less (-NaN < -Inf < ... < -0 < +0 < ... < +Inf < +NaN, payload ordered); when undefined, o[13] = 0 and no totalOrder logic exists.

Structure
REQ-026 SHALL place in shared package fp_cmp_pkg: EMSB/FMSB derivation functions of FPWID, localparams for every o bit index.
REQ-027 SHALL use one sub-module fp_decomp_n (parametrised by FPWID) instantiated twice for sign/exponent/fraction/zero/inf/nan/qnan/snan decode.

Verification
REQ-028 SHALL test FPWID=64, a=0x0000000000000000, b=0x8000000000000000 -> o[0]=1, o[2]=1, o[8]=0, o[4]=0 two cycles after accept.
REQ-029 SHALL test a=0xBFF0000000000000 (-1.0), b=0x4000000000000000 (2.0) -> o[1]=1, o[3]=1 (|a|<|b|), o[10]=0.
REQ-030 SHALL test a=0x7FF8000000000000, b=0x3FF0000000000000 -> o[4]=1, o[8]=1, o[0]=o[1]=0, nan=1, snan=0, snan_sticky unchanged.
REQ-031 SHALL test a=0x7FF0000000000001 -> snan=1, snan_sticky=1 and held until flag_clr; flag_clr coincident with new sNaN leaves sticky 1.
REQ-032 SHALL test back-to-back issue of tags 1,2,3 with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, outputs hold tag 1, tags then delivered 1,2,3 in order without loss or duplicate.
REQ-033 SHALL test rst asserted with both stages full -> out_valid=0 next cycle and no stale tag ever appears.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the IEEE 754 compare pipeline: field-width helpers
// and the bit positions of the compare result vector.
package fp_cmp_pkg;

    localparam int O_W   = 16;
    localparam int O_EQ  = 0;
    localparam int O_LT  = 1;
    localparam int O_LE  = 2;
    localparam int O_MLT = 3;
    localparam int O_UN  = 4;
    localparam int O_NE  = 8;
    localparam int O_GE  = 9;
    localparam int O_GT  = 10;
    localparam int O_MGE = 11;
    localparam int O_ORD = 12;
    localparam int O_TOT = 13;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
    } cmp_flags_t;

    // Exponent width of the IEEE binary16/32/64/128 interchange formats.
    function automatic int exp_w(input int fpwid);
        case (fpwid)
            16:      return 5;
            32:      return 8;
            128:     return 15;
            default: return 11;
        endcase
    endfunction

    function automatic int emsb(input int fpwid);
        return exp_w(fpwid) - 1;
    endfunction

    function automatic int fmsb(input int fpwid);
        return fpwid - exp_w(fpwid) - 2;
    endfunction

endpackage

// File: rtl/fp_cmp_decomp.sv
// Splits one IEEE 754 operand into sign/exponent/fraction and classifies it.
module fp_decomp_n
    import fp_cmp_pkg::*;
#(
    parameter int FPWID = 64,
    localparam int EMSB = emsb(FPWID),
    localparam int FMSB = fmsb(FPWID)
) (
    input  logic [FPWID-1:0] i,
    output logic             sgn,
    output logic [EMSB:0]    expo,
    output logic [FMSB:0]    frac,
    output logic             zero,
    output logic             inf,
    output logic             nan,
    output logic             qnan,
    output logic             snan
);

    logic exp_max;
    logic frac_zero;

    assign sgn       = i[FPWID-1];
    assign expo      = i[FPWID-2 -: EMSB+1];
    assign frac      = i[FMSB:0];
    assign exp_max   = &expo;
    assign frac_zero = ~|frac;

    // Subnormals are non-zero; only an all-zero exponent and fraction is zero.
    assign zero = ~|expo & frac_zero;
    assign inf  = exp_max & frac_zero;
    assign nan  = exp_max & ~frac_zero;
    assign qnan = nan & frac[FMSB];
    assign snan = nan & ~frac[FMSB];

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready IEEE 754 comparator producing a 16-bit predicate vector.
// Optional o[13] totalOrder strict-less is built only when FP_CMP_TOTALORDER_EN is defined.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int FPWID = 64,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [O_W-1:0]   o,
    output logic [TAGW-1:0]  out_tag,
    output logic             nan,
    output logic             snan,
    output logic             inf,
    output logic             snan_sticky,
    input  logic             flag_clr
);

    localparam int EMSB = emsb(FPWID);
    localparam int FMSB = fmsb(FPWID);
    localparam int MW   = EMSB + FMSB + 2;

    typedef struct packed {
        logic          sgn;
        logic [MW-1:0] mag;
        logic          zero;
        logic          inf;
        logic          nan;
        logic          qnan;
        logic          snan;
    } opnd_t;

    logic          sa, sb_, za, zb, ia, ib, na, nb, qa, qb, xa, xb;
    logic [EMSB:0] ea, eb;
    logic [FMSB:0] fa, fb;
    opnd_t         op_a, op_b;

    fp_decomp_n #(.FPWID(FPWID)) u_dec_a (
        .i(a), .sgn(sa), .expo(ea), .frac(fa), .zero(za),
        .inf(ia), .nan(na), .qnan(qa), .snan(xa)
    );

    fp_decomp_n #(.FPWID(FPWID)) u_dec_b (
        .i(b), .sgn(sb_), .expo(eb), .frac(fb), .zero(zb),
        .inf(ib), .nan(nb), .qnan(qb), .snan(xb)
    );

    assign op_a = '{sgn: sa,  mag: {ea, fa}, zero: za, inf: ia, nan: na, qnan: qa, snan: xa};
    assign op_b = '{sgn: sb_, mag: {eb, fb}, zero: zb, inf: ib, nan: nb, qnan: qb, snan: xb};

    logic            v1;
    opnd_t           s1_a, s1_b;
    logic [TAGW-1:0] s1_tag;
    logic            s2_free;
    cmp_flags_t      flags_q;

    assign s2_free  = ~out_valid | out_ready;
    assign in_ready = ~v1 | s2_free;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
        end
    end

    // NOTE: operand and tag registers are not reset; v1 qualifies them, so
    // whatever they hold after reset is never observed.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_a   <= op_a;
            s1_b   <= op_b;
            s1_tag <= in_tag;
        end
    end

    logic           unord, both_zero, both_inf;
    logic           mag_lt, mag_gt, mag_eq;
    logic           lt_raw, eq_raw;
    logic [O_W-1:0] cmp_o;
    cmp_flags_t     cmp_flags;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        cmp_o     = '0;
        cmp_flags = '0;
        unord     = s1_a.nan | s1_b.nan;
        both_zero = s1_a.zero & s1_b.zero;
        both_inf  = s1_a.inf & s1_b.inf;
        mag_lt    = s1_a.mag < s1_b.mag;
        mag_gt    = s1_b.mag < s1_a.mag;
        mag_eq    = s1_a.mag == s1_b.mag;
        eq_raw    = both_zero | ((s1_a.sgn == s1_b.sgn) & mag_eq);
        lt_raw    = 1'b0;

        // Negative magnitudes order in reverse; a signed zero pair is equal.
        if (s1_a.sgn != s1_b.sgn) begin
            lt_raw = s1_a.sgn & ~both_zero;
        end else if (s1_a.sgn) begin
            lt_raw = mag_gt;
        end else begin
            lt_raw = mag_lt;
        end

        cmp_o[O_EQ]  = ~unord & eq_raw;
        cmp_o[O_LT]  = ~unord & lt_raw;
        cmp_o[O_LE]  = ~unord & (lt_raw | eq_raw);
        cmp_o[O_MLT] = mag_lt;
        cmp_o[O_UN]  = unord;
        cmp_o[O_NE]  = unord | ~eq_raw;
        cmp_o[O_GE]  = ~unord & ~lt_raw;
        cmp_o[O_GT]  = ~unord & ~lt_raw & ~eq_raw;
        cmp_o[O_MGE] = ~mag_lt;
        cmp_o[O_ORD] = ~unord;

`ifdef FP_CMP_TOTALORDER_EN
        // Raw sign/magnitude ordering: NaN payloads and signed zeros fall out naturally.
        if (s1_a.sgn != s1_b.sgn) begin
            cmp_o[O_TOT] = s1_a.sgn;
        end else if (s1_a.sgn) begin
            cmp_o[O_TOT] = mag_gt;
        end else begin
            cmp_o[O_TOT] = mag_lt;
        end
`else
        cmp_o[O_TOT] = 1'b0;
`endif

        cmp_flags.nan  = s1_a.qnan | s1_a.snan | s1_b.qnan | s1_b.snan | both_inf;
        cmp_flags.snan = s1_a.snan | s1_b.snan;
        cmp_flags.inf  = both_inf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o         <= '0;
            out_tag   <= '0;
            flags_q   <= '0;
        end else if (s2_free) begin
            out_valid <= v1;
            if (v1) begin
                o       <= cmp_o;
                out_tag <= s1_tag;
                flags_q <= cmp_flags;
            end
        end
    end

    assign nan  = flags_q.nan;
    assign snan = flags_q.snan;
    assign inf  = flags_q.inf;

    // A delivered sNaN result outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            snan_sticky <= 1'b0;
        end else if (out_valid && out_ready && flags_q.snan) begin
            snan_sticky <= 1'b1;
        end else if (flag_clr) begin
            snan_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe (FPWID=64) using hand-computed directed vectors.
module tb_fp_compare_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o;
    logic [3:0]  out_tag;
    logic        nan, snan, inf, snan_sticky;
    logic        flag_clr = 1'b0;

    fp_compare_pipe #(.FPWID(64), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .out_tag(out_tag), .nan(nan), .snan(snan), .inf(inf),
        .snan_sticky(snan_sticky), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ZP   = 64'h0000000000000000;
    localparam logic [63:0] ZN   = 64'h8000000000000000;
    localparam logic [63:0] P1   = 64'h3FF0000000000000;
    localparam logic [63:0] M1   = 64'hBFF0000000000000;
    localparam logic [63:0] P2   = 64'h4000000000000000;
    localparam logic [63:0] M2   = 64'hC000000000000000;
    localparam logic [63:0] QN   = 64'h7FF8000000000000;
    localparam logic [63:0] SN   = 64'h7FF0000000000001;
    localparam logic [63:0] NSN  = 64'hFFF0000000000001;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] NINF = 64'hFFF0000000000000;
    localparam logic [63:0] MAXF = 64'h7FEFFFFFFFFFFFFF;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] o;
        logic        nan;
        logic        snan;
        logic        inf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Adds the expected totalOrder bit when that feature is built in.
    function automatic logic [15:0] wt(input logic [15:0] base, input logic tot);
`ifdef FP_CMP_TOTALORDER_EN
        return base | {2'b00, tot, 13'b0};
`else
        return base | {15'b0, tot & 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [63:0] va, input logic [63:0] vb, input logic [3:0] t,
                         input logic [15:0] eo, input logic en, input logic es, input logic ei);
        exp_t e;
        bit   ok;
        a = va; b = vb; in_tag = t; in_valid = 1'b1;
        e.tag = t; e.o = eo; e.nan = en; e.snan = es; e.inf = ei;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                sb.push_back(e);
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept for tag %0d expected accept", t);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got tag %0d expected none", out_tag);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("tag[%0d]", e.tag),  64'(out_tag), 64'(e.tag));
                    check($sformatf("o[%0d]", e.tag),    64'(o),       64'(e.o));
                    check($sformatf("nan[%0d]", e.tag),  64'(nan),     64'(e.nan));
                    check($sformatf("snan[%0d]", e.tag), 64'(snan),    64'(e.snan));
                    check($sformatf("inf[%0d]", e.tag),  64'(inf),     64'(e.inf));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_o", 64'(o), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_flags", 64'({nan, snan, inf}), 64'd0);
        check("rst_sticky", 64'(snan_sticky), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        step();

        // +0 vs -0, with latency check
        issue(ZP, ZN, 4'd1, wt(16'h1A05, 1'b0), 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("lat_one_cycle", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_two_cycles", 64'(out_valid), 64'd1);
        step();

        issue(M1, P2, 4'd2, wt(16'h110E, 1'b1), 1'b0, 1'b0, 1'b0);
        issue(QN, P1, 4'd3, wt(16'h0910, 1'b0), 1'b1, 1'b0, 1'b0);
        idle();
        drain();
        @(negedge clk);
        check("sticky_qnan", 64'(snan_sticky), 64'd0);
        step();

        issue(SN, P1, 4'd4, wt(16'h0910, 1'b0), 1'b1, 1'b1, 1'b0);
        idle();
        drain();
        @(negedge clk);
        check("sticky_set", 64'(snan_sticky), 64'd1);
        step();

        issue(P2,   P1,   4'd5,  wt(16'h1F00, 1'b0), 1'b0, 1'b0, 1'b0);
        issue(NINF, PINF, 4'd6,  wt(16'h1906, 1'b1), 1'b1, 1'b0, 1'b1);
        issue(M2,   M1,   4'd7,  wt(16'h1906, 1'b1), 1'b0, 1'b0, 1'b0);
        issue(PINF, MAXF, 4'd8,  wt(16'h1F00, 1'b0), 1'b0, 1'b0, 1'b0);
        issue(ZN,   ZP,   4'd9,  wt(16'h1A05, 1'b1), 1'b0, 1'b0, 1'b0);
        issue(P1,   NSN,  4'd10, wt(16'h0118, 1'b0), 1'b1, 1'b1, 1'b0);
        idle();
        drain();
        @(negedge clk);
        check("sticky_held", 64'(snan_sticky), 64'd1);
        step();

        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 64'(snan_sticky), 64'd0);
        step();

        // sNaN delivered in the same cycle as flag_clr
        out_ready = 1'b0;
        issue(SN, P1, 4'd11, wt(16'h0910, 1'b0), 1'b1, 1'b1, 1'b0);
        idle();
        step();
        step();
        flag_clr  = 1'b1;
        out_ready = 1'b1;
        step();
        flag_clr = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", 64'(snan_sticky), 64'd1);
        step();

        // back-to-back tags 1,2,3 against a stalled output
        out_ready = 1'b0;
        issue(M1,   P2,   4'd1, wt(16'h110E, 1'b1), 1'b0, 1'b0, 1'b0);
        issue(NINF, PINF, 4'd2, wt(16'h1906, 1'b1), 1'b1, 1'b0, 1'b1);
        a = M2; b = M1; in_tag = 4'd3; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready[%0d]", i), 64'(in_ready), 64'd0);
            check($sformatf("stall_valid[%0d]", i), 64'(out_valid), 64'd1);
            check($sformatf("stall_tag[%0d]", i), 64'(out_tag), 64'd1);
            check($sformatf("stall_o[%0d]", i), 64'(o), 64'(wt(16'h110E, 1'b1)));
            step();
        end
        out_ready = 1'b1;
        issue(M2, M1, 4'd3, wt(16'h1906, 1'b1), 1'b0, 1'b0, 1'b0);
        idle();
        drain();

        // reset with both stages full
        out_ready = 1'b0;
        issue(P2,   P1,   4'd4, wt(16'h1F00, 1'b0), 1'b0, 1'b0, 1'b0);
        issue(PINF, MAXF, 4'd5, wt(16'h1F00, 1'b0), 1'b0, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        sb.delete();
        step();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_o", 64'(o), 64'd0);
        check("midrst_sticky", 64'(snan_sticky), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no_stale[%0d]", i), 64'(out_valid), 64'd0);
            step();
        end
        issue(P1, M1, 4'd6, wt(16'h1F00, 1'b0), 1'b0, 1'b0, 1'b0);
        idle();
        drain();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
